// File: rtl/lane_scatter_16_pkg.sv
// lane_scatter_16_pkg: lane geometry and per-frame metadata shared by the loader banks
package lane_scatter_16_pkg;
    localparam int LANES = 16;
    localparam int CNT_W = 4;
    localparam int LEN_W = 5;
    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             bcast;
    } frame_meta_t;
endpackage

// File: rtl/lane_bank_16.sv
// lane_bank_16: 16-lane register bank with per-lane write, broadcast write and zero-above-index mask
module lane_bank_16
    import lane_scatter_16_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] we,
    input  logic             bcast,
    input  logic             clr,
    input  logic [CNT_W-1:0] idx,
    input  logic [W-1:0]     din [LANES],
    output logic [W-1:0]     q [LANES]
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < LANES; i++) q[i] <= '0;
        else
            for (int i = 0; i < LANES; i++)
                q[i] <= (clr && i > int'(idx)) ? '0 : (bcast || we[i]) ? din[i] : q[i];
endmodule

// File: rtl/lane_scatter_16.sv
// lane_scatter_16: serial-to-parallel operand loader, fill bank double-buffered into a 16-lane output bank
module lane_scatter_16
    import lane_scatter_16_pkg::*;
#(
    parameter int ACC_BW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_BW-1:0] in_data,
    input  logic              in_last,
    input  logic              in_bcast,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_BW-1:0] out [LANES],
    output logic [LEN_W-1:0]  out_len,
    output logic              out_bcast
);
    logic [CNT_W-1:0]  cnt;
    logic              fill_full, acc, bc, nrm, close, xfer;
    logic [LANES-1:0]  fill_we;
    logic [ACC_BW-1:0] in_rep [LANES];
    logic [ACC_BW-1:0] fill_q [LANES];
    frame_meta_t       fill_meta, out_meta;
    assign xfer     = fill_full && (!out_valid || out_ready);
    assign in_ready = !fill_full || xfer;
    assign acc      = in_valid && in_ready;
    assign bc       = acc && cnt == '0 && in_bcast;
    assign nrm      = acc && !bc;
    assign close    = bc || (nrm && (cnt == CNT_W'(LANES - 1) || in_last));
    assign fill_we  = nrm ? LANES'(1) << cnt : '0;
    assign out_len   = out_meta.len;
    assign out_bcast = out_meta.bcast;
    always_comb
        for (int i = 0; i < LANES; i++) in_rep[i] = in_data;
    // Lanes above the closing index are zeroed so short frames never carry stale words
    lane_bank_16 #(.W(ACC_BW)) u_fill (
        .clk(clk), .rst_n(rst_n), .we(fill_we), .bcast(bc),
        .clr(nrm && close), .idx(cnt), .din(in_rep), .q(fill_q)
    );
    lane_bank_16 #(.W(ACC_BW)) u_out (
        .clk(clk), .rst_n(rst_n), .we('0), .bcast(xfer),
        .clr(1'b0), .idx('0), .din(fill_q), .q(out)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt       <= '0;
            fill_full <= 1'b0;
            out_valid <= 1'b0;
            fill_meta <= '0;
            out_meta  <= '0;
        end else begin
            cnt       <= close ? '0 : nrm ? cnt + 1'b1 : cnt;
            fill_full <= close || (fill_full && !xfer);
            out_valid <= xfer || (out_valid && !out_ready);
            if (close) fill_meta <= '{len: bc ? LEN_W'(LANES) : {1'b0, cnt} + 1'b1, bcast: bc};
            if (xfer) out_meta <= fill_meta;
        end
endmodule

// File: tb/tb_lane_scatter_16.sv
// tb_lane_scatter_16: randomized and directed checks of lane_scatter_16 against a frame-level model
module tb_lane_scatter_16;
    localparam int W = 32;
    typedef struct {
        logic [W-1:0] w [16];
        logic [4:0]   len;
        logic         bc;
    } frame_t;
    logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, in_bcast = 0, out_ready = 0;
    logic [W-1:0] in_data = '0;
    logic in_ready, out_valid, out_bcast;
    logic [W-1:0] out [16];
    logic [4:0] out_len;
    frame_t exp_q[$], got_q[$];
    logic [W-1:0] m_w [16];
    int m_n = 0, n_cmp = 0, n_bad = 0, waits = 0;

    lane_scatter_16 #(.ACC_BW(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_len(out_len), .out_bcast(out_bcast)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    // Frame-level reference: words accumulate until 16 or last; a leading broadcast word fills all lanes
    task automatic model(input logic [W-1:0] d, input logic last, input logic bc);
        frame_t f;
        if (m_n == 0 && bc) begin
            for (int i = 0; i < 16; i++) f.w[i] = d;
            f.len = 16;
            f.bc = 1;
            exp_q.push_back(f);
        end else begin
            m_w[m_n] = d;
            m_n++;
            if (m_n == 16 || last) begin
                for (int i = 0; i < 16; i++) f.w[i] = (i < m_n) ? m_w[i] : '0;
                f.len = 5'(m_n);
                f.bc = 0;
                exp_q.push_back(f);
                m_n = 0;
            end
        end
    endtask

    task automatic step(output bit a);
        frame_t f;
        #1;
        a = in_valid && in_ready;
        if (out_valid && out_ready) begin
            for (int i = 0; i < 16; i++) f.w[i] = out[i];
            f.len = out_len;
            f.bc = out_bcast;
            got_q.push_back(f);
        end
        if (a) model(in_data, in_last, in_bcast);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++) step(a);
    endtask

    task automatic send(input logic [W-1:0] d, input logic last, input logic bc);
        bit a = 0;
        waits = 0;
        in_valid = 1;
        in_data = d;
        in_last = last;
        in_bcast = bc;
        while (!a && waits < 100) begin
            step(a);
            waits++;
        end
        in_valid = 0;
        in_last = 0;
        in_bcast = 0;
        if (!a) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: word %h not accepted after %0d cycles", d, waits);
        end
    endtask

    task automatic drain();
        in_valid = 0;
        out_ready = 1;
        idle(40);
    endtask

    function automatic int frames_bad();
        int b = 0;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            if (got_q[k].len !== exp_q[k].len || got_q[k].bc !== exp_q[k].bc) b++;
            else
                for (int i = 0; i < 16; i++)
                    if (got_q[k].w[i] !== exp_q[k].w[i]) begin
                        b++;
                        break;
                    end
        end
        return b;
    endfunction

    task automatic test_reset();
        int z = 0;
        rst_n = 0;
        in_valid = 1;
        in_data = 32'h55;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) if (out[i] !== '0) z++;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (out_len !== 5'd0 || out_bcast !== 1'b0) begin n_bad++; $display("FAIL reset_meta: got len %0d bcast %b want 0 0", out_len, out_bcast); end
        n_cmp++;
        if (z != 0) begin n_bad++; $display("FAIL reset_lanes: %0d nonzero lanes want 0", z); end
        in_valid = 0;
        rst_n = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        idle(20);
        n_cmp++;
        if (out_valid !== 1'b0 || got_q.size() != 0) begin n_bad++; $display("FAIL reset_no_accept: out_valid %b frames %0d want 0 0", out_valid, got_q.size()); end
    endtask

    task automatic test_full();
        int stalls = 0, z = 0;
        out_ready = 1;
        for (int k = 1; k <= 16; k++) begin
            send(W'(k), 0, 0);
            stalls += waits - 1;
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_early: out_valid %b one edge after close want 0", out_valid); end
        idle(1);
        // first accept counted as edge 1: out_valid rises at edge 17, seen by the consumer at edge 18
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL full_latency: out_valid %b want 1", out_valid); end
        for (int i = 0; i < 16; i++) if (out[i] !== W'(i + 1)) z++;
        n_cmp++;
        if (z != 0) begin n_bad++; $display("FAIL full_lanes: %0d lanes differ from i+1", z); end
        n_cmp++;
        if (out_len !== 5'd16 || out_bcast !== 1'b0) begin n_bad++; $display("FAIL full_meta: len %0d bcast %b want 16 0", out_len, out_bcast); end
        n_cmp++;
        if (stalls != 0) begin n_bad++; $display("FAIL full_in_ready: %0d stall cycles want 0", stalls); end
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size() || frames_bad() != 0) begin n_bad++; $display("FAIL full_frames: got %0d frames (%0d differ) want %0d", got_q.size(), frames_bad(), exp_q.size()); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_bcast();
        int z = 0, stalls = 0;
        out_ready = 1;
        send(32'hA5, 0, 1);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bcast_early: out_valid %b want 0", out_valid); end
        idle(1);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bcast_latency: out_valid %b want 1", out_valid); end
        for (int i = 0; i < 16; i++) if (out[i] !== 32'hA5) z++;
        n_cmp++;
        if (z != 0 || out_len !== 5'd16 || out_bcast !== 1'b1) begin n_bad++; $display("FAIL bcast_frame: %0d lanes differ, len %0d bcast %b want 0 16 1", z, out_len, out_bcast); end
        for (int k = 0; k < 6; k++) begin
            send($urandom, 1'($urandom), 1);
            stalls += waits - 1;
        end
        n_cmp++;
        if (stalls != 0) begin n_bad++; $display("FAIL bcast_rate: %0d stall cycles want 0", stalls); end
        drain();
        n_cmp++;
        if (got_q.size() != 7 || exp_q.size() != 7 || frames_bad() != 0) begin n_bad++; $display("FAIL bcast_frames: got %0d frames (%0d differ) want 7", got_q.size(), frames_bad()); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_short();
        int z = 0;
        out_ready = 1;
        for (int k = 0; k < 16; k++) send(32'hFF, 0, 0);
        send(7, 0, 0);
        send(8, 0, 0);
        send(9, 1, 0);
        drain();
        n_cmp++;
        if (got_q.size() != 2) begin
            n_bad++;
            $display("FAIL short_count: got %0d frames want 2", got_q.size());
        end else begin
            for (int i = 0; i < 16; i++) if (got_q[1].w[i] !== ((i < 3) ? W'(i + 7) : '0)) z++;
            if (z != 0 || got_q[1].len !== 5'd3 || got_q[1].bc !== 1'b0) begin
                n_bad++;
                $display("FAIL short_frame: %0d lanes differ, len %0d bcast %b want 0 3 0", z, got_q[1].len, got_q[1].bc);
            end
        end
        n_cmp++;
        if (got_q.size() != exp_q.size() || frames_bad() != 0) begin n_bad++; $display("FAIL short_model: got %0d frames (%0d differ) want %0d", got_q.size(), frames_bad(), exp_q.size()); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] f [48];
        int accepted = 0, z = 0;
        bit a;
        for (int i = 0; i < 48; i++) f[i] = $urandom;
        out_ready = 0;
        for (int i = 0; i < 32; i++) send(f[i], 0, 0);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_drop: got %b want 0", in_ready); end
        in_valid = 1;
        in_data = f[32];
        for (int k = 0; k < 5; k++) begin
            step(a);
            if (a) accepted++;
        end
        n_cmp++;
        if (accepted != 0) begin n_bad++; $display("FAIL bp_accept_while_full: %0d words accepted want 0", accepted); end
        for (int i = 0; i < 16; i++) if (exp_q.size() == 0 || out[i] !== exp_q[0].w[i]) z++;
        n_cmp++;
        if (out_valid !== 1'b1 || z != 0) begin n_bad++; $display("FAIL bp_hold: out_valid %b, %0d lanes differ from frame 1, want 1 0", out_valid, z); end
        out_ready = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_rise: got %b want 1", in_ready); end
        for (int i = 32; i < 48; i++) send(f[i], 0, 0);
        drain();
        n_cmp++;
        if (got_q.size() != 3 || exp_q.size() != 3 || frames_bad() != 0) begin n_bad++; $display("FAIL bp_frames: got %0d frames (%0d differ) want 3", got_q.size(), frames_bad()); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_bcast_ignored();
        out_ready = 1;
        for (int k = 0; k < 16; k++) send(W'(100 + k), 0, k == 5);
        drain();
        n_cmp++;
        if (got_q.size() != 1 || got_q[0].bc !== 1'b0 || got_q[0].len !== 5'd16 || got_q[0].w[5] !== W'(105)) begin
            n_bad++;
            $display("FAIL bcast_ignored: frames %0d, bcast %b len %0d lane5 %0d want 1 0 16 105", got_q.size(),
                     got_q.size() ? got_q[0].bc : 1'bx, got_q.size() ? got_q[0].len : 5'bx, got_q.size() ? got_q[0].w[5] : 'x);
        end
        n_cmp++;
        if (got_q.size() != exp_q.size() || frames_bad() != 0) begin n_bad++; $display("FAIL bcast_ignored_model: got %0d frames (%0d differ)", got_q.size(), frames_bad()); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int z = 0;
        out_ready = 1;
        for (int k = 0; k < 9; k++) send($urandom, 0, 0);
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < 16; i++) if (out[i] !== '0) z++;
        n_cmp++;
        if (out_valid !== 1'b0 || out_len !== 5'd0 || z != 0) begin n_bad++; $display("FAIL rst_mid_outputs: out_valid %b len %0d nonzero lanes %0d want 0 0 0", out_valid, out_len, z); end
        m_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        for (int k = 0; k < 16; k++) send($urandom, 0, 0);
        drain();
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1 || frames_bad() != 0) begin n_bad++; $display("FAIL rst_mid_clean: got %0d frames (%0d differ) want 1", got_q.size(), frames_bad()); end
        got_q.delete();
        exp_q.delete();
        out_ready = 0;
        for (int k = 0; k < 16; k++) send($urandom, 0, 0);
        idle(2);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pend_setup: out_valid %b want 1", out_valid); end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_bcast !== 1'b0 || out[0] !== '0) begin n_bad++; $display("FAIL rst_pend_drop: out_valid %b bcast %b lane0 %h want 0 0 0", out_valid, out_bcast, out[0]); end
        exp_q.delete();
        m_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;
        for (int k = 0; k < 16; k++) send($urandom, 0, 0);
        drain();
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1 || frames_bad() != 0) begin n_bad++; $display("FAIL rst_pend_clean: got %0d frames (%0d differ) want 1", got_q.size(), frames_bad()); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        bit a;
        for (int k = 0; k < 800; k++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data = $urandom;
            in_last = $urandom_range(0, 7) == 0;
            in_bcast = $urandom_range(0, 5) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            step(a);
        end
        in_valid = 0;
        in_last = 0;
        in_bcast = 0;
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size() || exp_q.size() == 0 || frames_bad() != 0) begin n_bad++; $display("FAIL random_stream: got %0d frames (%0d differ) want %0d", got_q.size(), frames_bad(), exp_q.size()); end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_full();
        test_bcast();
        test_short();
        test_backpressure();
        test_bcast_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
